// File: rtl/msk_share_encoder_if.sv
// Handshake bundle for msk_share_encoder: unmasked input, randomness input and shared output.
// Every channel transfers exactly on a rising clk edge where valid and ready are both high; a
// producer holds valid and its payload steady until that edge, and ready may depend on state only.
interface msk_share_encoder_if #(
   parameter int d     = 2,
   parameter int count = 8,
   parameter int RND_W = 8
);
   logic [count-1:0]   in_data;
   logic               in_valid;
   logic               in_ready;
   logic [RND_W-1:0]   rnd_data;
   logic               rnd_valid;
   logic               rnd_ready;
   logic [count*d-1:0] out_shares;
   logic               out_valid;
   logic               out_ready;

   modport slave (
      input  in_data, in_valid, rnd_data, rnd_valid, out_ready,
      output in_ready, rnd_ready, out_shares, out_valid
   );

   modport master (
      output in_data, in_valid, rnd_data, rnd_valid, out_ready,
      input  in_ready, rnd_ready, out_shares, out_valid
   );
endinterface

// File: rtl/msk_share_encoder.sv
// Boolean masking encoder: splits an unmasked word into d bit-interleaved shares using fresh randomness.
// Optional MSKENC_SCRUB_EN clears the data and mask registers on the output handshake.
module msk_share_encoder #(
   parameter int d     = 2,
   parameter int count = 8,
   parameter int RND_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   msk_share_encoder_if.slave  bus_if,
   output logic [1:0]          dbg_state_o
);

   localparam int MASK_W = (d - 1) * count;
   localparam int NBEATS = (MASK_W + RND_W - 1) / RND_W;
   localparam int BUF_W  = NBEATS * RND_W;
   localparam int CNT_W  = $clog2(NBEATS + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [count-1:0]   data_q, data_d;
   logic [MASK_W-1:0]  m_q, m_d;
   logic [CNT_W-1:0]   beat_q, beat_d;
   logic [BUF_W-1:0]   mbuf;
   logic [count*d-1:0] shares;
   logic               acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         m_q     <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         m_q     <= m_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      data_d           = data_q;
      m_d              = m_q;
      beat_d           = beat_q;
      mbuf             = BUF_W'(m_q);
      bus_if.in_ready  = 1'b0;
      bus_if.rnd_ready = 1'b0;
      bus_if.out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus_if.in_ready = 1'b1;
            if (bus_if.in_valid) begin
               data_d  = bus_if.in_data;
               beat_d  = '0;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            bus_if.rnd_ready = 1'b1;
            if (bus_if.rnd_valid) begin
               // Surplus bits of the final beat land above MASK_W and are dropped by the truncation.
               mbuf[int'(beat_q)*RND_W +: RND_W] = bus_if.rnd_data;
               m_d    = mbuf[MASK_W-1:0];
               beat_d = CNT_W'(beat_q + 1'b1);
               if (beat_q == CNT_W'(NBEATS - 1)) begin
                  state_d = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            bus_if.out_valid = 1'b1;
            if (bus_if.out_ready) begin
               state_d = IDLE;
`ifdef MSKENC_SCRUB_EN
               data_d = '0;
               m_d    = '0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shares are a function of registers only, so no input reaches out_shares combinationally.
   always_comb begin
      shares = '0;
      acc    = 1'b0;
      for (int i = 0; i < count; i++) begin
         acc = data_q[i];
         for (int j = 1; j < d; j++) begin
            shares[i*d+j] = m_q[(j-1)*count+i];
            acc           = acc ^ m_q[(j-1)*count+i];
         end
         shares[i*d] = acc;
      end
   end

   assign bus_if.out_shares = (state_q == OUTPUT) ? shares : '0;
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_msk_share_encoder.sv
// Directed bench for msk_share_encoder: three parameterisations share one clock and one scoreboard.
module tb_msk_share_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   logic [23:0] exp_q[$];

   // index 0: d=2,count=8,RND_W=8   1: d=3,count=8,RND_W=4   2: d=2,count=5,RND_W=8
   int nb[3] = '{1, 4, 1};
   int rw[3] = '{8, 4, 8};

   logic        rst_v[3];
   logic [7:0]  in_data_v[3];
   logic        in_valid_v[3];
   logic [7:0]  rnd_data_v[3];
   logic        rnd_valid_v[3];
   logic        out_ready_v[3];
   logic        in_ready_v[3];
   logic        rnd_ready_v[3];
   logic        out_valid_v[3];
   logic [23:0] shares_v[3];
   logic [1:0]  dbg_a, dbg_b, dbg_c;
   int          xfer[3] = '{0, 0, 0};

   msk_share_encoder_if #(.d(2), .count(8), .RND_W(8)) ifa ();
   msk_share_encoder_if #(.d(3), .count(8), .RND_W(4)) ifb ();
   msk_share_encoder_if #(.d(2), .count(5), .RND_W(8)) ifc ();

   msk_share_encoder #(.d(2), .count(8), .RND_W(8)) dut_a (
      .clk(clk), .rst_n(rst_v[0]), .bus_if(ifa), .dbg_state_o(dbg_a));
   msk_share_encoder #(.d(3), .count(8), .RND_W(4)) dut_b (
      .clk(clk), .rst_n(rst_v[1]), .bus_if(ifb), .dbg_state_o(dbg_b));
   msk_share_encoder #(.d(2), .count(5), .RND_W(8)) dut_c (
      .clk(clk), .rst_n(rst_v[2]), .bus_if(ifc), .dbg_state_o(dbg_c));

   assign ifa.in_data   = in_data_v[0];
   assign ifb.in_data   = in_data_v[1];
   assign ifc.in_data   = in_data_v[2][4:0];
   assign ifa.in_valid  = in_valid_v[0];
   assign ifb.in_valid  = in_valid_v[1];
   assign ifc.in_valid  = in_valid_v[2];
   assign ifa.rnd_data  = rnd_data_v[0];
   assign ifb.rnd_data  = rnd_data_v[1][3:0];
   assign ifc.rnd_data  = rnd_data_v[2];
   assign ifa.rnd_valid = rnd_valid_v[0];
   assign ifb.rnd_valid = rnd_valid_v[1];
   assign ifc.rnd_valid = rnd_valid_v[2];
   assign ifa.out_ready = out_ready_v[0];
   assign ifb.out_ready = out_ready_v[1];
   assign ifc.out_ready = out_ready_v[2];

   assign in_ready_v[0]  = ifa.in_ready;
   assign in_ready_v[1]  = ifb.in_ready;
   assign in_ready_v[2]  = ifc.in_ready;
   assign rnd_ready_v[0] = ifa.rnd_ready;
   assign rnd_ready_v[1] = ifb.rnd_ready;
   assign rnd_ready_v[2] = ifc.rnd_ready;
   assign out_valid_v[0] = ifa.out_valid;
   assign out_valid_v[1] = ifb.out_valid;
   assign out_valid_v[2] = ifc.out_valid;
   assign shares_v[0]    = 24'(ifa.out_shares);
   assign shares_v[1]    = 24'(ifb.out_shares);
   assign shares_v[2]    = 24'(ifc.out_shares);

   always @(posedge clk) begin
      for (int s = 0; s < 3; s++) begin
         if (out_valid_v[s] && out_ready_v[s]) xfer[s] <= xfer[s] + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Interleave per-share words: bit i of share j goes to index i*dd+j.
   function automatic logic [23:0] il(input int dd, input int cnt,
                                      input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
      logic [23:0] r = '0;
      for (int i = 0; i < cnt; i++) begin
         r[i*dd]   = s0[i];
         r[i*dd+1] = s1[i];
         if (dd == 3) r[i*dd+2] = s2[i];
      end
      return r;
   endfunction

   function automatic logic [23:0] model(input int dd, input int cnt,
                                         input logic [7:0] data, input logic [31:0] mask);
      logic [7:0] cm = 8'((32'd1 << cnt) - 1);
      logic [7:0] s1 = 8'(mask) & cm;
      logic [7:0] s2 = (dd == 3) ? (8'(mask >> cnt) & cm) : 8'h00;
      logic [7:0] s0 = (data ^ s1 ^ s2) & cm;
      return il(dd, cnt, s0, s1, s2);
   endfunction

   // Starts and ends just after a falling edge with the encoder in IDLE.
   task automatic run(input int s, input logic [7:0] data, input logic [31:0] mask,
                      input int rnd_stall, input int out_stall, input int exp_lat,
                      input logic [23:0] exp_sh);
      int cyc;
      int k;
      logic [23:0] first;
      logic [31:0] bm;
      exp_q.push_back(exp_sh);
      check("idle_in_ready", 32'(in_ready_v[s]), 1);
      in_data_v[s]  = data;
      in_valid_v[s] = 1'b1;
      @(negedge clk);
      cyc = 1;
      in_valid_v[s] = 1'b0;
      check("busy_in_ready", 32'(in_ready_v[s]), 0);
      repeat (rnd_stall) begin
         in_valid_v[s] = 1'b1;
         in_data_v[s]  = ~data;
         check("rnd_ready_held", 32'(rnd_ready_v[s]), 1);
         check("stall_in_ready", 32'(in_ready_v[s]), 0);
         @(negedge clk);
         cyc++;
      end
      in_valid_v[s] = 1'b0;
      bm = (32'd1 << rw[s]) - 1;
      for (k = 0; k < nb[s]; k++) begin
         rnd_data_v[s]  = 8'((mask >> (k * rw[s])) & bm);
         rnd_valid_v[s] = 1'b1;
         @(negedge clk);
         cyc++;
      end
      rnd_valid_v[s] = 1'b0;
      k = 0;
      while (!out_valid_v[s] && k < 50) begin
         @(negedge clk);
         cyc++;
         k++;
      end
      check("out_valid_rise", 32'(out_valid_v[s]), 1);
      if (exp_lat != 0) check("latency", 32'(cyc), 32'(exp_lat));
      first = shares_v[s];
      repeat (out_stall) begin
         check("hold_valid", 32'(out_valid_v[s]), 1);
         check("hold_shares", 32'(shares_v[s]), 32'(first));
         @(negedge clk);
      end
      out_ready_v[s] = 1'b1;
      check("shares", 32'(shares_v[s]), 32'(exp_q.pop_front()));
      @(negedge clk);
      out_ready_v[s] = 1'b0;
      check("post_out_valid", 32'(out_valid_v[s]), 0);
      check("post_in_ready", 32'(in_ready_v[s]), 1);
   endtask

   initial begin
      logic [7:0]  dv;
      logic [31:0] mv;
      for (int s = 0; s < 3; s++) begin
         rst_v[s] = 1'b0; in_data_v[s] = '0; in_valid_v[s] = 1'b0;
         rnd_data_v[s] = '0; rnd_valid_v[s] = 1'b0; out_ready_v[s] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) rst_v[s] = 1'b1;
      @(negedge clk);

      for (int s = 0; s < 3; s++) begin
         check("rst_in_ready", 32'(in_ready_v[s]), 1);
         check("rst_rnd_ready", 32'(rnd_ready_v[s]), 0);
         check("rst_out_valid", 32'(out_valid_v[s]), 0);
         check("rst_shares", 32'(shares_v[s]), 0);
      end
      check("rst_state_a", 32'(dbg_a), 0);

      run(0, 8'hA5, 32'h3C, 0, 0, 2, il(2, 8, 8'h99, 8'h3C, 8'h00));
`ifdef MSKENC_SCRUB_EN
      check("scrub_data", 32'(dut_a.data_q), 0);
      check("scrub_mask", 32'(dut_a.m_q), 0);
`else
      check("keep_data", 32'(dut_a.data_q), 32'hA5);
      check("keep_mask", 32'(dut_a.m_q), 32'h3C);
`endif

      for (int n = 0; n < 3; n++) begin
         dv = 8'($urandom_range(0, 255));
         mv = 32'($urandom_range(0, 255));
         run(0, dv, mv, 0, 0, 2, model(2, 8, dv, mv));
      end
      dv = 8'($urandom_range(0, 255));
      mv = 32'($urandom_range(0, 255));
      run(0, dv, mv, 3, 4, 0, model(2, 8, dv, mv));

      run(1, 8'hF0, 32'h4321, 0, 0, 5, il(3, 8, 8'h92, 8'h21, 8'h43));
      dv = 8'($urandom_range(0, 255));
      mv = 32'($urandom_range(0, 65535));
      run(1, dv, mv, 2, 2, 0, model(3, 8, dv, mv));

      in_data_v[1]  = 8'h55;
      in_valid_v[1] = 1'b1;
      @(negedge clk);
      in_valid_v[1]  = 1'b0;
      rnd_data_v[1]  = 8'h07;
      rnd_valid_v[1] = 1'b1;
      @(negedge clk);
      rnd_valid_v[1] = 1'b0;
      check("mid_collect_state", 32'(dbg_b), 1);
      rst_v[1] = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid_v[1]), 0);
      check("arst_rnd_ready", 32'(rnd_ready_v[1]), 0);
      check("arst_in_ready", 32'(in_ready_v[1]), 1);
      check("arst_state", 32'(dbg_b), 0);
      check("arst_beat", 32'(dut_b.beat_q), 0);
      check("arst_data", 32'(dut_b.data_q), 0);
      check("arst_mask", 32'(dut_b.m_q), 0);
      @(negedge clk);
      rst_v[1] = 1'b1;
      @(negedge clk);
      check("rel_out_valid", 32'(out_valid_v[1]), 0);
      check("rel_shares", 32'(shares_v[1]), 0);
      run(1, 8'h00, 32'h0, 0, 0, 5, 24'h0);

      run(2, 8'h0A, 32'hFF, 0, 0, 2, il(2, 5, 8'h15, 8'h1F, 8'h00));
      dv = 8'($urandom_range(0, 31));
      mv = 32'($urandom_range(0, 255));
      run(2, dv, mv, 1, 1, 0, model(2, 5, dv, mv));

      @(negedge clk);
      check("xfer_a", 32'(xfer[0]), 5);
      check("xfer_b", 32'(xfer[1]), 3);
      check("xfer_c", 32'(xfer[2]), 2);
      check("queue_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
